iseq_dispatcher: RTL and testbench

ISEQ_DISPATCHER -- requirements
Module: iseq_dispatcher

---
 rtl/iseq_dispatcher_if.sv | 41 ++++
 rtl/iseq_dispatcher.sv | 215 +++++++++++++++++++++
 tb/tb_iseq_dispatcher.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/iseq_dispatcher_if.sv
// Dispatcher signal bundle: start/ready handshake, instruction and write-data FIFO
// reads, the two PHY command slots with write data, and completion status.
interface iseq_dispatcher_if;
  logic         process_iseq;
  logic         dispatcher_ready;
  logic         instr0_empty;
  logic         instr1_empty;
  logic [31:0]  instr0_data;
  logic [31:0]  instr1_data;
  logic         instr0_rd_en;
  logic         instr1_rd_en;
  logic         wrdata_empty;
  logic [511:0] wrdata_data;
  logic         wrdata_rd_en;
  logic [31:0]  phy_cmd0;
  logic [31:0]  phy_cmd1;
  logic         phy_cmd0_valid;
  logic         phy_cmd1_valid;
  logic [511:0] phy_wrdata;
  logic         phy_wrdata_valid;
  logic         iseq_done;
  logic [31:0]  iseq_cycles;

  // Dispatcher view
  modport master (
    input  process_iseq, instr0_empty, instr1_empty, instr0_data, instr1_data,
           wrdata_empty, wrdata_data,
    output dispatcher_ready, instr0_rd_en, instr1_rd_en, wrdata_rd_en,
           phy_cmd0, phy_cmd1, phy_cmd0_valid, phy_cmd1_valid,
           phy_wrdata, phy_wrdata_valid, iseq_done, iseq_cycles
  );

  // Receiver / FIFO / PHY view
  modport slave (
    output process_iseq, instr0_empty, instr1_empty, instr0_data, instr1_data,
           wrdata_empty, wrdata_data,
    input  dispatcher_ready, instr0_rd_en, instr1_rd_en, wrdata_rd_en,
           phy_cmd0, phy_cmd1, phy_cmd0_valid, phy_cmd1_valid,
           phy_wrdata, phy_wrdata_valid, iseq_done, iseq_cycles
  );
endinterface

// File: rtl/iseq_dispatcher.sv
// Pops instruction pairs from two FWFT FIFOs and issues them as two PHY command slots per clk.
// Optional ISEQ_CYCLE_COUNT_EN adds a saturating RUN/WAIT/SPLIT cycle counter on iseq_cycles.
`ifndef END_ISEQ
`define END_ISEQ 4'b0010
`endif
`ifndef CAS_OFFSET
`define CAS_OFFSET 21
`endif
`ifndef WE_OFFSET
`define WE_OFFSET 20
`endif

module iseq_dispatcher (
  input logic               clk,
  input logic               rst,
  iseq_dispatcher_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SPLIT = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]   state, state_nxt;
  logic [28:0]  wait_cnt, wait_cnt_nxt;
  logic [31:0]  split_cmd, split_cmd_nxt;

  logic         rd0, rd1, rdw;
  logic [31:0]  cmd0_q, cmd1_q, cmd0_nxt, cmd1_nxt;
  logic         v0_q, v1_q, v0_nxt, v1_nxt;
  logic         wv_q, wv_nxt;
  logic [511:0] wd_q, wd_nxt;

  logic [31:0]  h0, h1;
  logic         e0, e1, we;
  logic         end0, end1, wait0, wait1, wr0, wr1;
  logic [28:0]  wait_sum;

  function automatic logic is_end(input logic [31:0] w);
    return w[31:28] == `END_ISEQ;
  endfunction

  function automatic logic is_wait(input logic [31:0] w);
    return w[31:28] == 4'b0001;
  endfunction

  function automatic logic is_write(input logic [31:0] w);
    return w[31] & ~w[`CAS_OFFSET] & ~w[`WE_OFFSET];
  endfunction

  assign h0    = bus.instr0_data;
  assign h1    = bus.instr1_data;
  assign e0    = bus.instr0_empty;
  assign e1    = bus.instr1_empty;
  assign we    = bus.wrdata_empty;
  assign end0  = is_end(h0);
  assign end1  = is_end(h1);
  assign wait0 = is_wait(h0);
  assign wait1 = is_wait(h1);
  assign wr0   = is_write(h0) & ~end0 & ~wait0;
  assign wr1   = is_write(h1) & ~end1 & ~wait1;

  // Two WAIT words in one pair stall for the sum of both counts.
  assign wait_sum = (wait0 ? {1'b0, h0[27:0]} : 29'd0) + (wait1 ? {1'b0, h1[27:0]} : 29'd0);

  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    split_cmd_nxt = split_cmd;
    rd0           = 1'b0;
    rd1           = 1'b0;
    rdw           = 1'b0;
    cmd0_nxt      = '0;
    cmd1_nxt      = '0;
    v0_nxt        = 1'b0;
    v1_nxt        = 1'b0;
    wv_nxt        = 1'b0;
    wd_nxt        = '0;
    case (state)
      S_IDLE: begin
        if (bus.process_iseq) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (!e0 && !e1) begin
          if (end0) begin
            rd0       = 1'b1;
            state_nxt = S_DONE;
          end else if (wr0 && wr1) begin
            // Only one data beat per cycle: slot0 goes now, slot1 is parked for SPLIT.
            if (!we) begin
              rd0           = 1'b1;
              rd1           = 1'b1;
              rdw           = 1'b1;
              cmd0_nxt      = h0;
              v0_nxt        = 1'b1;
              wv_nxt        = 1'b1;
              wd_nxt        = bus.wrdata_data;
              split_cmd_nxt = h1;
              state_nxt     = S_SPLIT;
            end
          end else if (!((wr0 || wr1) && we)) begin
            rd0 = 1'b1;
            rd1 = 1'b1;
            if (!wait0) begin
              cmd0_nxt = h0;
              v0_nxt   = 1'b1;
            end
            if (!end1 && !wait1) begin
              cmd1_nxt = h1;
              v1_nxt   = 1'b1;
            end
            if (wr0 || wr1) begin
              rdw    = 1'b1;
              wv_nxt = 1'b1;
              wd_nxt = bus.wrdata_data;
            end
            if (end1) begin
              state_nxt = S_DONE;
            end else if (wait_sum != '0) begin
              wait_cnt_nxt = wait_sum;
              state_nxt    = S_WAIT;
            end
          end
        end else if (!e0 && e1 && end0) begin
          rd0       = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_WAIT: begin
        if (wait_cnt <= 29'd1) begin
          wait_cnt_nxt = '0;
          state_nxt    = S_RUN;
        end else begin
          wait_cnt_nxt = wait_cnt - 29'd1;
        end
      end
      S_SPLIT: begin
        if (!we) begin
          rdw       = 1'b1;
          cmd1_nxt  = split_cmd;
          v1_nxt    = 1'b1;
          wv_nxt    = 1'b1;
          wd_nxt    = bus.wrdata_data;
          state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      split_cmd <= '0;
      cmd0_q    <= '0;
      cmd1_q    <= '0;
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      wv_q      <= 1'b0;
      wd_q      <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      split_cmd <= split_cmd_nxt;
      cmd0_q    <= cmd0_nxt;
      cmd1_q    <= cmd1_nxt;
      v0_q      <= v0_nxt;
      v1_q      <= v1_nxt;
      wv_q      <= wv_nxt;
      wd_q      <= wd_nxt;
    end
  end

  assign bus.instr0_rd_en     = rd0 & ~rst;
  assign bus.instr1_rd_en     = rd1 & ~rst;
  assign bus.wrdata_rd_en     = rdw & ~rst;
  assign bus.dispatcher_ready = (state == S_IDLE);
  assign bus.iseq_done        = (state == S_DONE);
  assign bus.phy_cmd0         = cmd0_q;
  assign bus.phy_cmd1         = cmd1_q;
  assign bus.phy_cmd0_valid   = v0_q;
  assign bus.phy_cmd1_valid   = v1_q;
  assign bus.phy_wrdata       = wd_q;
  assign bus.phy_wrdata_valid = wv_q;

`ifdef ISEQ_CYCLE_COUNT_EN
  logic [31:0] cyc_cnt, cyc_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt  <= '0;
      cyc_last <= '0;
    end else begin
      if (state == S_IDLE && bus.process_iseq) begin
        cyc_cnt <= '0;
      end else if ((state == S_RUN || state == S_WAIT || state == S_SPLIT) && cyc_cnt != '1) begin
        cyc_cnt <= cyc_cnt + 32'd1;
      end
      if (state == S_DONE) cyc_last <= cyc_cnt;
    end
  end

  assign bus.iseq_cycles = cyc_last;
`else
  assign bus.iseq_cycles = '0;
`endif

endmodule

// File: tb/tb_iseq_dispatcher.sv
// Directed bench for iseq_dispatcher: FIFO queues feed the DUT, each cycle's
// outputs are snapshotted at negedge and compared with hand-derived values.
module tb_iseq_dispatcher;
  logic clk;
  logic rst;

  iseq_dispatcher_if bus ();

  iseq_dispatcher dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] END_W  = 32'h2000_0000;
  localparam logic [31:0] ACT_A0 = 32'h8030_0100;
  localparam logic [31:0] ACT_A1 = 32'h8030_0201;
  localparam logic [31:0] ACT_A2 = 32'h8030_0302;
  localparam logic [31:0] ACT_A3 = 32'h8030_0403;
  localparam logic [31:0] ACT_B  = 32'h4030_0007;
  localparam logic [31:0] WR_0   = 32'h8000_0040;
  localparam logic [31:0] WR_1   = 32'h8000_0080;
  localparam logic [31:0] WAIT5  = 32'h1000_0005;
  localparam logic [31:0] WAIT100 = 32'h1000_0064;

  logic [31:0]  q0[$];
  logic [31:0]  q1[$];
  logic [511:0] qw[$];

  int unsigned n_cmp;
  int unsigned n_err;

  logic         s_rd0, s_rd1, s_rdw, s_v0, s_v1, s_wv, s_done, s_ready;
  logic [31:0]  s_c0, s_c1, s_cyc;
  logic [511:0] s_wd;

  logic [511:0] d0, d1, d2;
  logic [31:0]  exp_cyc;
  int unsigned  wait_rd;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    bus.instr0_empty = (q0.size() == 0);
    bus.instr0_data  = (q0.size() != 0) ? q0[0] : '0;
    bus.instr1_empty = (q1.size() == 0);
    bus.instr1_data  = (q1.size() != 0) ? q1[0] : '0;
    bus.wrdata_empty = (qw.size() == 0);
    bus.wrdata_data  = (qw.size() != 0) ? qw[0] : '0;
  endtask

  // Snapshot the current cycle at negedge, then apply its pops just after posedge.
  task automatic tick();
    @(negedge clk);
    s_rd0   = bus.instr0_rd_en;
    s_rd1   = bus.instr1_rd_en;
    s_rdw   = bus.wrdata_rd_en;
    s_v0    = bus.phy_cmd0_valid;
    s_v1    = bus.phy_cmd1_valid;
    s_c0    = bus.phy_cmd0;
    s_c1    = bus.phy_cmd1;
    s_wv    = bus.phy_wrdata_valid;
    s_wd    = bus.phy_wrdata;
    s_done  = bus.iseq_done;
    s_ready = bus.dispatcher_ready;
    s_cyc   = bus.iseq_cycles;
    @(posedge clk);
    #1;
    if (s_rd0 && q0.size() != 0) void'(q0.pop_front());
    if (s_rd1 && q1.size() != 0) void'(q1.pop_front());
    if (s_rdw && qw.size() != 0) void'(qw.pop_front());
    drive();
  endtask

  task automatic start();
    drive();
    bus.process_iseq = 1'b1;
    tick();
    bus.process_iseq = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    d0 = {16{32'hA5A5_0000}};
    d1 = {16{32'h5A5A_1111}};
    d2 = {16{32'hC3C3_2222}};
`ifdef ISEQ_CYCLE_COUNT_EN
    exp_cyc = 32'd3;
`else
    exp_cyc = 32'd0;
`endif
    rst = 1'b1;
    bus.process_iseq = 1'b0;
    drive();
    tick();
    tick();
    chk("rst_rd0", s_rd0, 0);
    rst = 1'b0;
    tick();
    chk("rst_ready", s_ready, 1);
    chk("rst_v0", s_v0, 0);
    chk("rst_cmd1", s_c1, 0);
    chk("rst_wv", s_wv, 0);
    chk("rst_done", s_done, 0);
    chk("rst_cyc", s_cyc, 0);

    // Two plain pairs then END alone in instr0
    q0 = '{ACT_A0, ACT_A2, END_W};
    q1 = '{ACT_A1, ACT_A3};
    start();
    chk("t1_idle_ready", s_ready, 1);
    tick();
    chk("t1_pop1_rd0", s_rd0, 1);
    chk("t1_pop1_rd1", s_rd1, 1);
    chk("t1_pop1_v0", s_v0, 0);
    tick();
    chk("t1_pop2_rd1", s_rd1, 1);
    chk("t1_out1_c0", s_c0, ACT_A0);
    chk("t1_out1_c1", s_c1, ACT_A1);
    chk("t1_out1_v1", s_v1, 1);
    chk("t1_out1_ready", s_ready, 0);
    tick();
    chk("t1_end_rd0", s_rd0, 1);
    chk("t1_end_rd1", s_rd1, 0);
    chk("t1_out2_c0", s_c0, ACT_A2);
    chk("t1_out2_c1", s_c1, ACT_A3);
    tick();
    chk("t1_done", s_done, 1);
    chk("t1_done_v0", s_v0, 0);
    chk("t1_done_v1", s_v1, 0);
    chk("t1_done_ready", s_ready, 0);
    tick();
    chk("t1_after_done", s_done, 0);
    chk("t1_after_ready", s_ready, 1);
    chk("t1_cycles", s_cyc, exp_cyc);

    // WAIT 5 in slot0, ACT in slot1
    q0 = '{WAIT5, END_W};
    q1 = '{ACT_B};
    start();
    tick();
    chk("t2_pop_rd0", s_rd0, 1);
    chk("t2_pop_rd1", s_rd1, 1);
    wait_rd = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (s_rd0 || s_rd1 || s_rdw) wait_rd++;
      if (i == 0) begin
        chk("t2_v0", s_v0, 0);
        chk("t2_c0", s_c0, 0);
        chk("t2_v1", s_v1, 1);
        chk("t2_c1", s_c1, ACT_B);
      end
    end
    chk("t2_wait_rd_cycles", wait_rd, 0);
    tick();
    chk("t2_resume_rd0", s_rd0, 1);
    tick();
    chk("t2_done", s_done, 1);
    tick();

    // Write/write pair splits across two cycles
    q0 = '{WR_0, END_W};
    q1 = '{WR_1};
    qw = '{d0, d1};
    start();
    tick();
    chk("t3_pop_rd0", s_rd0, 1);
    chk("t3_pop_rdw", s_rdw, 1);
    tick();
    chk("t3_split_rdw", s_rdw, 1);
    chk("t3_split_rd0", s_rd0, 0);
    chk("t3_s0_c0", s_c0, WR_0);
    chk("t3_s0_v1", s_v1, 0);
    chk("t3_s0_wv", s_wv, 1);
    chk("t3_s0_wd", s_wd, d0);
    tick();
    chk("t3_s1_v0", s_v0, 0);
    chk("t3_s1_c1", s_c1, WR_1);
    chk("t3_s1_v1", s_v1, 1);
    chk("t3_s1_wd", s_wd, d1);
    chk("t3_end_rd0", s_rd0, 1);
    tick();
    chk("t3_done", s_done, 1);
    chk("t3_done_wv", s_wv, 0);
    tick();
    chk("t3_cycles", s_cyc, exp_cyc);

    // Write pair stalls while write data is missing
    q0 = '{WR_0, END_W};
    q1 = '{ACT_B};
    start();
    wait_rd = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (s_rd0 || s_rd1 || s_rdw) wait_rd++;
    end
    chk("t4_stall_rd_cycles", wait_rd, 0);
    qw.push_back(d2);
    drive();
    tick();
    chk("t4_issue_rd0", s_rd0, 1);
    chk("t4_issue_rdw", s_rdw, 1);
    tick();
    chk("t4_c0", s_c0, WR_0);
    chk("t4_c1", s_c1, ACT_B);
    chk("t4_wd", s_wd, d2);
    chk("t4_wv", s_wv, 1);
    tick();
    chk("t4_done", s_done, 1);
    tick();

    // Reset during a long WAIT
    q0 = '{WAIT100, END_W};
    q1 = '{ACT_B};
    start();
    tick();
    chk("t5_pop_rd1", s_rd1, 1);
    rst = 1'b1;
    tick();
    chk("t5_rst_rd0", s_rd0, 0);
    chk("t5_rst_v1_pre", s_v1, 1);
    rst = 1'b0;
    tick();
    chk("t5_ready", s_ready, 1);
    chk("t5_v1", s_v1, 0);
    chk("t5_c1", s_c1, 0);
    chk("t5_done", s_done, 0);
    start();
    tick();
    chk("t5_restart_rd0", s_rd0, 1);
    tick();
    chk("t5_restart_done", s_done, 1);
    tick();

    // END in slot1: slot0 issues alone
    q0 = '{ACT_A2};
    q1 = '{END_W};
    start();
    tick();
    chk("t6_rd1", s_rd1, 1);
    tick();
    chk("t6_done", s_done, 1);
    chk("t6_c0", s_c0, ACT_A2);
    chk("t6_v0", s_v0, 1);
    chk("t6_v1", s_v1, 0);
    chk("t6_c1", s_c1, 0);
    tick();
    chk("t6_ready", s_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
